// File: rtl/mult_seq_ctrl.sv
// Sequential wrapper around the combinational 8x8 array multiplier: registers operands,
// waits a fixed settle window, captures the product and hands it downstream over valid/ready.
module mult_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        ovf,
  output logic        busy,
  output logic [7:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("mult_seq_ctrl: SETTLE_CYCLES must be within 1..15");
    end
  endgenerate

  // Overflow means any bit above the low byte is set.
  function automatic logic upper_byte_set(input logic [15:0] p);
    return |p[15:8];
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [7:0]  mul_b_q, mul_b_d;
  logic [15:0] product_q, product_d;
  logic        ovf_q, ovf_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  op_count_q, op_count_d;

  // Next-state and datapath update for the IDLE/SETTLE/HOLD sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    product_d  = product_q;
    ovf_d      = ovf_q;
    op_count_d = op_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mul_a_d = a_in;
          mul_b_d = b_in;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          product_d = mul_p;
          ovf_d     = upper_byte_set(mul_p);
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    out_valid_d = (state_d == HOLD);
  end

  // State and output registers; reset discards any in-flight product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      mul_a_q     <= 8'd0;
      mul_b_q     <= 8'd0;
      product_q   <= 16'd0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      product_q   <= product_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign product   = product_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: scoreboard of expected products, default and SETTLE_CYCLES=1 builds.
module tb_mult_seq_ctrl;

  localparam int S = 2;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, ovf, busy;
  logic [7:0]  a_in, b_in, mul_a, mul_b, op_count;
  logic [15:0] mul_p, product;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, ovf1, busy1;
  logic [7:0]  a_in1, b_in1, mul_a1, mul_b1, op_count1;
  logic [15:0] mul_p1, product1;

  int n_cmp;
  int n_bad;
  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  logic [7:0]  exp_cnt;
  int          lat;

  int   acc, done, last, bad_int, cyc;
  logic acc_now, done_now;

  mult_seq_ctrl #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .ovf(ovf), .busy(busy), .op_count(op_count)
  );

  mult_seq_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a_in1), .b_in(b_in1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
    .out_valid(out_valid1), .out_ready(out_ready1), .product(product1),
    .ovf(ovf1), .busy(busy1), .op_count(op_count1)
  );

  // Stand-in for the combinational array multiplier.
  assign mul_p  = {8'h00, mul_a} * {8'h00, mul_b};
  assign mul_p1 = {8'h00, mul_a1} * {8'h00, mul_b1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b, input bit push);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    tick();
    in_valid = 1'b0;
    if (push) exp_q.push_back({1'b0, {8'h00, a} * {8'h00, b}} | {((({8'h00, a} * {8'h00, b}) >> 8) != 16'd0), 16'd0});
    chk("mul_a", 32'(mul_a), 32'(a));
    chk("mul_b", 32'(mul_b), 32'(b));
    chk("busy_settle", 32'(busy), 32'd1);
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      tick();
      cycles++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic consume();
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      exp_v = 17'd0;
    end else begin
      exp_v = exp_q.pop_front();
    end
    chk("product", 32'(product), 32'(exp_v[15:0]));
    chk("ovf", 32'(ovf), 32'(exp_v[16]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 8'd1;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(exp_cnt));
    chk("product_retained", 32'(product), 32'(exp_v[15:0]));
  endtask

  task automatic full_op(input logic [7:0] a, input logic [7:0] b);
    accept(a, b, 1'b1);
    wait_out(lat);
    chk("latency", 32'(lat), 32'(S));
    consume();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; exp_cnt = 8'd0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = 8'd0; b_in = 8'd0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a_in1 = 8'd0; b_in1 = 8'd0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);

    full_op(8'd12, 8'd10);
    full_op(8'd255, 8'd255);
    full_op(8'd16, 8'd16);
    full_op(8'd15, 8'd17);

    // Backpressure with new operands waiting upstream.
    accept(8'd7, 8'd9, 1'b1);
    wait_out(lat);
    in_valid = 1'b1; a_in = 8'd3; b_in = 8'd3;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_product", 32'(product), 32'd63);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_mul_a", 32'(mul_a), 32'd7);
    consume();
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    full_op(8'd3, 8'd3);

    // Reset one cycle into SETTLE discards the product.
    accept(8'd200, 8'd2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_product", 32'(product), 32'd0);
    chk("mrst_op_count", 32'(op_count), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    tick(); tick(); tick();
    chk("mrst_no_400", 32'(product), 32'd0);

    // 256 back-to-back transfers, checking issue spacing and counter wrap.
    in_valid = 1'b1; a_in = 8'd1; b_in = 8'd1; out_ready = 1'b1;
    acc = 0; done = 0; last = -1; bad_int = 0; cyc = 0;
    while (done < 256 && cyc < 2000) begin
      acc_now  = in_valid && in_ready;
      done_now = out_valid && out_ready;
      if (done_now) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h1ffff;
        chk("b2b_product", 32'(product), 32'(exp_v[15:0]));
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (last >= 0 && (cyc - last) != S + 2) bad_int++;
        last = cyc;
        acc++;
        exp_q.push_back(17'd1);
      end
      if (done_now) begin
        done++;
        if (done == 255) chk("b2b_count_255", 32'(op_count), 32'd255);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_done", 32'(done), 32'd256);
    chk("b2b_accepts", 32'(acc), 32'd256);
    chk("b2b_spacing", 32'(bad_int), 32'd0);
    chk("b2b_wrap", 32'(op_count), 32'd0);
    exp_q.delete();

    // SETTLE_CYCLES=1 build: capture one edge after accept.
    in_valid1 = 1'b1; a_in1 = 8'd20; b_in1 = 8'd20;
    tick();
    in_valid1 = 1'b0;
    chk("s1_busy", 32'(busy1), 32'd1);
    tick();
    chk("s1_valid_a", 32'(out_valid1), 32'd1);
    chk("s1_product_a", 32'(product1), 32'd400);
    chk("s1_ovf_a", 32'(ovf1), 32'd1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    chk("s1_count_a", 32'(op_count1), 32'd1);
    in_valid1 = 1'b1; a_in1 = 8'd0; b_in1 = 8'd200;
    tick();
    in_valid1 = 1'b0;
    chk("s1_not_yet", 32'(out_valid1), 32'd0);
    tick();
    chk("s1_valid_b", 32'(out_valid1), 32'd1);
    chk("s1_product_b", 32'(product1), 32'd0);
    chk("s1_ovf_b", 32'(ovf1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
